// File: rtl/cle_pkg.sv
// Shared constants and types for the CLE label-memory arbiter.
package cle_pkg;

    localparam int unsigned CLE_AW   = 10;
    localparam int unsigned CLE_DW   = 8;
    localparam int unsigned CLE_NREQ = 2;

    typedef logic [0:0] req_id_t;

    localparam logic SRAM_WEN_WRITE = 1'b0;
    localparam logic SRAM_WEN_READ  = 1'b1;

    // One stage of the read-return tag pipeline.
    typedef struct packed {
        logic    vld;
        req_id_t id;
    } rd_tag_t;

endpackage

// File: rtl/cle_rr_pick.sv
// Two-way round-robin picker; ptr_i names the favoured requester when both ask.
// A valid lock forces the grant to its owner and freezes the pointer.
module cle_rr_pick
    import cle_pkg::*;
(
    input  logic [CLE_NREQ-1:0] req_i,
    input  req_id_t             ptr_i,
    input  logic                lock_vld_i,
    input  req_id_t             lock_id_i,
    output logic [CLE_NREQ-1:0] gnt_o,
    output req_id_t             ptr_o
);

    always_comb begin
        gnt_o = '0;
        ptr_o = ptr_i;
        if (lock_vld_i && req_i[lock_id_i]) begin
            gnt_o[lock_id_i] = 1'b1;
        end else if (req_i == 2'b11) begin
            gnt_o[ptr_i] = 1'b1;
            ptr_o        = ~ptr_i;
        end else if (req_i[0]) begin
            gnt_o = 2'b01;
            ptr_o = req_id_t'(1'b1);
        end else if (req_i[1]) begin
            gnt_o = 2'b10;
            ptr_o = req_id_t'(1'b0);
        end
    end

endmodule

// File: rtl/cle_sram_arb.sv
// Round-robin arbiter sharing the single-port label SRAM between two requesters.
// Optional bus lock for atomic read-modify-write: define SRAM_ARB_LOCK_EN.
module cle_sram_arb
    import cle_pkg::*;
#(
    parameter int unsigned AW = CLE_AW,
    parameter int unsigned DW = CLE_DW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      m_req,
    input  logic [1:0]      m_wen,
    input  logic [2*AW-1:0] m_a,
    input  logic [2*DW-1:0] m_d,
    input  logic [1:0]      m_lock,
    output logic [1:0]      m_gnt,
    output logic [1:0]      m_rvalid,
    output logic [DW-1:0]   m_q,
    output logic [AW-1:0]   sram_a,
    output logic [DW-1:0]   sram_d,
    output logic            sram_wen,
    input  logic [DW-1:0]   sram_q
);

    logic [1:0]    req_c;
    logic [1:0]    gnt_c;
    logic          gnt_any_c;
    req_id_t       gnt_id_c;
    req_id_t       ptr_q, ptr_d;
    logic          lock_vld_q, lock_vld_d;
    req_id_t       lock_id_q, lock_id_d;
    logic [AW-1:0] sram_a_q, sram_a_d;
    logic [DW-1:0] sram_d_q, sram_d_d;
    logic          sram_wen_q, sram_wen_d;
    rd_tag_t       tag1_q, tag1_d, tag2_q;

    // No grants while reset is held.
    assign req_c = reset ? m_req : 2'b00;

    cle_rr_pick u_pick (
        .req_i      (req_c),
        .ptr_i      (ptr_q),
        .lock_vld_i (lock_vld_q),
        .lock_id_i  (lock_id_q),
        .gnt_o      (gnt_c),
        .ptr_o      (ptr_d)
    );

    assign gnt_any_c = |gnt_c;
    assign gnt_id_c  = req_id_t'(gnt_c[1]);
    assign m_gnt     = gnt_c;

`ifdef SRAM_ARB_LOCK_EN
    // Lock follows every grant; released when the owner stops requesting.
    always_comb begin
        lock_vld_d = lock_vld_q;
        lock_id_d  = lock_id_q;
        if (gnt_any_c) begin
            lock_vld_d = m_lock[gnt_id_c];
            lock_id_d  = gnt_id_c;
        end else if (!req_c[lock_id_q]) begin
            lock_vld_d = 1'b0;
        end
    end
`else
    logic lock_unused;
    assign lock_unused = ^m_lock;
    assign lock_vld_d  = 1'b0;
    assign lock_id_d   = req_id_t'(1'b0);
`endif

    always_comb begin
        sram_a_d   = sram_a_q;
        sram_d_d   = sram_d_q;
        sram_wen_d = SRAM_WEN_READ;
        tag1_d     = '0;
        if (gnt_any_c) begin
            sram_a_d   = gnt_id_c[0] ? m_a[2*AW-1:AW] : m_a[AW-1:0];
            sram_d_d   = gnt_id_c[0] ? m_d[2*DW-1:DW] : m_d[DW-1:0];
            sram_wen_d = m_wen[gnt_id_c];
            tag1_d.vld = (m_wen[gnt_id_c] == SRAM_WEN_READ);
            tag1_d.id  = gnt_id_c;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q      <= req_id_t'(1'b0);
            lock_vld_q <= 1'b0;
            lock_id_q  <= req_id_t'(1'b0);
            sram_a_q   <= '0;
            sram_d_q   <= '0;
            sram_wen_q <= SRAM_WEN_READ;
            tag1_q     <= '0;
            tag2_q     <= '0;
        end else begin
            ptr_q      <= ptr_d;
            lock_vld_q <= lock_vld_d;
            lock_id_q  <= lock_id_d;
            sram_a_q   <= sram_a_d;
            sram_d_q   <= sram_d_d;
            sram_wen_q <= sram_wen_d;
            tag1_q     <= tag1_d;
            tag2_q     <= tag1_q;
        end
    end

    assign sram_a   = sram_a_q;
    assign sram_d   = sram_d_q;
    assign sram_wen = sram_wen_q;
    assign m_q      = sram_q;
    assign m_rvalid = tag2_q.vld ? ((tag2_q.id == req_id_t'(1'b1)) ? 2'b10 : 2'b01) : 2'b00;

endmodule
